// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns one-byte SPI frames into register read/write bursts over a
// 16 x 8 bank whose low addresses are RW configuration and high addresses are RO status.
module spi_reg_ctrl #(
    parameter int RO_BASE = 12,
    parameter int TIMEOUT = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_data_tick,
    input  logic [7:0]                    rx_data,
    output logic [7:0]                    tx_data,
    output logic [8*RO_BASE-1:0]          regs_out,
    input  logic [8*(16-RO_BASE)-1:0]     status_in,
    output logic                          wr_tick,
    output logic [3:0]                    wr_addr,
    output logic                          busy,
    output logic [7:0]                    err_count
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [3:0] RO = 4'(RO_BASE);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    state_t state, state_next;
    logic [3:0] addr, addr_inc, remain;
    logic [TW-1:0] timer;
    logic expire, last;
    logic [7:0] bank [16];

    // Unified read view: RW registers below RO_BASE, live status above.
    always_comb begin
        bank = '{default: 8'h00};
        for (int k = 0; k < RO_BASE; k++) bank[k] = regs_out[8*k +: 8];
        for (int k = RO_BASE; k < 16; k++) bank[k] = status_in[8*(k-RO_BASE) +: 8];
    end

    assign addr_inc = addr + 4'd1;
    assign last     = remain == 4'd1;
    assign busy     = state != IDLE;
    assign expire   = busy && !rx_data_tick && timer == TMAX;

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = rx_data_tick ? (rx_data[7] ? READ : WRITE) : IDLE;
        else if (expire || (rx_data_tick && last))
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data   <= 8'h00;
            regs_out  <= '0;
            wr_tick   <= 1'b0;
            wr_addr   <= 4'd0;
            err_count <= 8'h00;
            addr      <= 4'd0;
            remain    <= 4'd0;
            timer     <= '0;
        end else begin
            wr_tick <= 1'b0;
            if (state == IDLE) begin
                timer <= '0;
                if (rx_data_tick) begin
                    addr    <= rx_data[3:0];
                    remain  <= {1'b0, rx_data[6:4]} + 4'd1;
                    tx_data <= rx_data[7] ? bank[rx_data[3:0]] : 8'h00;
                end
            end else if (rx_data_tick) begin
                timer  <= '0;
                addr   <= addr_inc;
                remain <= remain - 4'd1;
                if (state == WRITE) begin
                    if (addr < RO) begin
                        for (int k = 0; k < RO_BASE; k++)
                            if (addr == 4'(k)) regs_out[8*k +: 8] <= rx_data;
                        wr_tick <= 1'b1;
                        wr_addr <= addr;
                    end else if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end else begin
                    tx_data <= last ? 8'h00 : bank[addr_inc];
                end
            end else if (expire) begin
                timer   <= '0;
                tx_data <= 8'h00;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed vector table plus hand sequences for timeout and async reset.
module tb_spi_reg_ctrl;
    logic        clk = 1'b0, reset = 1'b0, rx_data_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] status_in = 32'hC3C2C1C0;
    logic [7:0]  tx_data, err_count;
    logic [95:0] regs_out;
    logic        wr_tick, busy;
    logic [3:0]  wr_addr;
    int errors = 0, checks = 0;

    spi_reg_ctrl #(.RO_BASE(12), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .rx_data_tick(rx_data_tick), .rx_data(rx_data),
        .tx_data(tx_data), .regs_out(regs_out), .status_in(status_in),
        .wr_tick(wr_tick), .wr_addr(wr_addr), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       t;
        logic [7:0] d;
        logic [7:0] tx;
        logic       bsy;
        logic       wr;
        logic [3:0] wa;
        logic [7:0] err;
    } vec_t;
    vec_t vecs [21];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic [7:0] d);
        @(negedge clk);
        rx_data_tick = t;
        rx_data = d;
        @(posedge clk);
        #1;
        rx_data_tick = 1'b0;
    endtask

    function automatic logic [7:0] rg(input int k);
        return regs_out[8*k +: 8];
    endfunction

    initial begin
        // single write, wrapping write burst, writes to 5/6, reads incl. RO boundary and wrap
        vecs[0]  = '{1'b1, 8'h03, 8'h00, 1'b1, 1'b0, 4'd0, 8'd0};
        vecs[1]  = '{1'b1, 8'hA5, 8'h00, 1'b0, 1'b1, 4'd3, 8'd0};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd3, 8'd0};
        vecs[3]  = '{1'b1, 8'h3E, 8'h00, 1'b1, 1'b0, 4'd3, 8'd0};
        vecs[4]  = '{1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 4'd3, 8'd1};
        vecs[5]  = '{1'b1, 8'h22, 8'h00, 1'b1, 1'b0, 4'd3, 8'd2};
        vecs[6]  = '{1'b1, 8'h33, 8'h00, 1'b1, 1'b1, 4'd0, 8'd2};
        vecs[7]  = '{1'b1, 8'h44, 8'h00, 1'b0, 1'b1, 4'd1, 8'd2};
        vecs[8]  = '{1'b1, 8'h15, 8'h00, 1'b1, 1'b0, 4'd1, 8'd2};
        vecs[9]  = '{1'b1, 8'h5A, 8'h00, 1'b1, 1'b1, 4'd5, 8'd2};
        vecs[10] = '{1'b1, 8'hC3, 8'h00, 1'b0, 1'b1, 4'd6, 8'd2};
        vecs[11] = '{1'b1, 8'h95, 8'h5A, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[12] = '{1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[13] = '{1'b1, 8'h00, 8'hC3, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[14] = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 4'd6, 8'd2};
        vecs[15] = '{1'b1, 8'h9B, 8'h00, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[16] = '{1'b1, 8'h00, 8'hC0, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[17] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 4'd6, 8'd2};
        vecs[18] = '{1'b1, 8'h9F, 8'hC3, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[19] = '{1'b1, 8'h00, 8'h33, 1'b1, 1'b0, 4'd6, 8'd2};
        vecs[20] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 4'd6, 8'd2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst tx", tx_data, 8'h00);
        chk("rst busy", busy, 1'b0);
        chk("rst wr_tick", wr_tick, 1'b0);
        chk("rst err", err_count, 8'h00);
        chk("rst reg0", rg(0), 8'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cyc(vecs[i].t, vecs[i].d);
            chk($sformatf("v%0d tx", i), tx_data, vecs[i].tx);
            chk($sformatf("v%0d busy", i), busy, vecs[i].bsy);
            chk($sformatf("v%0d wr_tick", i), wr_tick, vecs[i].wr);
            chk($sformatf("v%0d wr_addr", i), wr_addr, vecs[i].wa);
            chk($sformatf("v%0d err", i), err_count, vecs[i].err);
        end
        chk("reg0", rg(0), 8'h33);
        chk("reg1", rg(1), 8'h44);
        chk("reg3", rg(3), 8'hA5);
        chk("reg5", rg(5), 8'h5A);
        chk("reg6", rg(6), 8'hC3);

        // RO read holds its sampled value until the next dummy tick
        status_in[7:0] = 8'h7E;
        cyc(1'b1, 8'h9C);
        chk("ro tx0", tx_data, 8'h7E);
        status_in[15:0] = 16'h5D11;
        cyc(1'b0, 8'h00);
        chk("ro hold", tx_data, 8'h7E);
        cyc(1'b1, 8'h00);
        chk("ro tx1", tx_data, 8'h5D);
        cyc(1'b1, 8'h00);
        chk("ro end tx", tx_data, 8'h00);
        chk("ro end busy", busy, 1'b0);

        // timeout after 16 idle cycles, partial write kept
        cyc(1'b1, 8'h10);
        cyc(1'b1, 8'hAB);
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 8'h00);
            if (k == 15) chk("to busy15", busy, 1'b1);
            if (k == 16) chk("to busy16", busy, 1'b0);
        end
        chk("to err", err_count, 8'd3);
        chk("to reg0", rg(0), 8'hAB);
        chk("to tx", tx_data, 8'h00);

        // tick on the expiry cycle is processed instead of timing out
        cyc(1'b1, 8'h20);
        cyc(1'b1, 8'h01);
        repeat (15) cyc(1'b0, 8'h00);
        chk("exp pre busy", busy, 1'b1);
        cyc(1'b1, 8'h02);
        chk("exp busy", busy, 1'b1);
        chk("exp reg1", rg(1), 8'h02);
        chk("exp wr_tick", wr_tick, 1'b1);
        chk("exp wr_addr", wr_addr, 4'd1);
        chk("exp err", err_count, 8'd3);
        cyc(1'b1, 8'h03);
        chk("exp end busy", busy, 1'b0);
        chk("exp reg2", rg(2), 8'h03);
        chk("exp end err", err_count, 8'd3);

        // asynchronous reset in the middle of a read
        cyc(1'b1, 8'h85);
        chk("ar tx", tx_data, 8'h5A);
        chk("ar busy", busy, 1'b1);
        #3 reset = 1'b0;
        #1;
        chk("ar rst tx", tx_data, 8'h00);
        chk("ar rst busy", busy, 1'b0);
        chk("ar rst reg5", rg(5), 8'h00);
        chk("ar rst reg0", rg(0), 8'h00);
        chk("ar rst err", err_count, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'hFF);
        chk("ar reg1", rg(1), 8'hFF);
        chk("ar wr_tick", wr_tick, 1'b1);
        chk("ar wr_addr", wr_addr, 4'd1);
        chk("ar end busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command controller behind the byte-wide SPI slave in the PWM firmware. It decodes frames from the slave (rx_data_tick/rx_data) into register read and write bursts. It owns a 16 x 8-bit register bank: RW configuration registers drive the PWM datapath, and RO registers are fed from status inputs. It drives the slave's tx_data so read data is ready before the next frame starts. Each SPI frame carries one byte.

Parameters:
RO_BASE, 12, first read-only address; addresses 0..RO_BASE-1 are RW, RO_BASE..15 are RO (legal range 1..15)
TIMEOUT, 1000000, clk cycles without rx_data_tick before an in-progress burst is abandoned (>=2)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low (0 = reset asserted)
rx_data_tick  input  1  one-cycle pulse from SPI slave: rx_data holds a completed byte
rx_data  input  8  received byte, valid while rx_data_tick=1
tx_data  output  8  byte the SPI slave loads at next frame start; registered
regs_out  output  8*RO_BASE  RW register bank, reg k at bits [8k+7:8k]
status_in  input  8*(16-RO_BASE)  RO register values, RO reg (RO_BASE+j) at bits [8j+7:8j]
wr_tick  output  1  one-cycle pulse when an RW register was written
wr_addr  output  4  address of last write, valid with wr_tick
busy  output  1  1 when state != IDLE
err_count  output  8  saturating error counter (timeouts + writes to RO addresses)

Behaviour:
- Reset (reset=0, async): state=IDLE, regs_out=0, tx_data=0x00, wr_tick=0, wr_addr=0, err_count=0, internal addr/len/timer=0.
- Command byte, taken in IDLE on rx_data_tick:
  - bit7: 1=read, 0=write.
  - bits6:4: len-1, so a burst is 1..8 bytes.
  - bits3:0: start address A.
- States: IDLE, WRITE, READ.
- IDLE + tick:
  - Latch addr=A and remain=len.
  - Write command: go to WRITE; tx_data=0x00.
  - Read command: go to READ; next cycle tx_data=reg[A] (1-cycle latency after tick).
- WRITE + tick:
  - addr<RO_BASE: regs_out[addr]<=rx_data; wr_tick=1 and wr_addr=addr on the following cycle.
  - addr>=RO_BASE: no write, no wr_tick, err_count+1.
  - Then addr<=addr+1 (mod 16) and remain<=remain-1.
  - remain reaches 0: go to IDLE.
- READ + tick:
  - rx_data is ignored (dummy byte); remain<=remain-1; addr<=addr+1 (mod 16).
  - Bytes remain: tx_data<=reg[new addr].
  - Last byte: tx_data<=0x00 and go to IDLE.
- Read data source:
  - RW addresses read regs_out.
  - RO addresses read status_in, sampled on the cycle tx_data is loaded.
- Address wrap: 15 -> 0; a burst may span the RW/RO boundary, with each byte handled per its address.
- Timeout:
  - In WRITE/READ the timer increments every clk and clears on any tick.
  - When the timer reaches TIMEOUT-1: go to IDLE, tx_data=0x00, err_count+1. Partially written registers keep their values.
  - A tick on the same cycle as timeout expiry wins: the byte is processed and the timer clears.
- err_count saturates at 0xFF and is cleared only by reset.
- wr_tick is high for exactly one cycle per accepted write byte.
- busy is combinational from state.
- Reset mid-burst: everything returns to reset values immediately; no partial register update after reset deasserts.

Test Plan:
- Single write: reset, tick 0x03 then tick 0xA5 -> regs_out[3]=0xA5; wr_tick one cycle with wr_addr=3; busy 1 then 0; err_count=0.
- Burst write with wrap, RO_BASE=12: tick 0x3E (len 4, A=14), data 0x11,0x22,0x33,0x44.
  - Addresses 14,15 are RO: ignored, err_count=2.
  - reg0=0x33, reg1=0x44; two wr_ticks (addr 0, 1); IDLE after the 4th byte.
- Burst read: regs 5,6 = 0x5A,0xC3; tick 0x95 (read, len 2, A=5).
  - tx_data=0x5A one cycle after tick; after dummy tick tx_data=0xC3; after second dummy tick tx_data=0x00 and IDLE.
- RO read: status_in for addr 12 = 0x7E; tick 0x8C -> tx_data=0x7E; change status_in before the dummy tick; tx_data does not change until that tick.
- Timeout, TIMEOUT=16: tick 0x10 (write, len 2, A=0), one data byte, then idle.
  - busy drops after 16 cycles; err_count=1; reg0 keeps the written byte.
  - Tick exactly on the expiry cycle -> processed, no error.
- Async reset mid-READ: assert reset between clk edges -> tx_data=0x00, busy=0, regs_out=0 immediately.
  - After release, tick 0x01 + 0xFF -> reg1=0xFF.
